reg_file_dump: RTL and testbench
================================

# reg_file_dump

Read-side sequencer for the 16 x 8 register file. After a start pulse it walks an inclusive, wrapping address range through the file's two read ports and packs the two read bytes into one 16-bit word. It streams those words out over a valid/ready handshake, for debug dump, context save and bench checking. It sits beside the register file and only ever drives the read-address inputs; it never writes.

## Interface
- ADDR_W, 4, register-file address width (16 entries)
- DATA_W, 8, register-file data width; out_data is 2*DATA_W
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  in  1  one-cycle request to begin a dump; honoured only in IDLE
- first_addr  in  ADDR_W  first register of the range, sampled with start
- last_addr  in  ADDR_W  last register of the range (inclusive), sampled with start
- ra1  out  ADDR_W  read address 1 to the register file; equals cur
- ra2  out  ADDR_W  read address 2 to the register file; equals (cur+1) mod 16
- rd1  in  DATA_W  register-file data_out1 (combinational from ra1)
- rd2  in  DATA_W  register-file data_out2 (combinational from ra2)
- out_valid  out  1  out_data/out_addr/out_single hold a word
- out_ready  in  1  consumer accepts the word
- out_data  out  2*DATA_W  {rd2, rd1}; rd1 is in the low byte
- out_addr  out  ADDR_W  address of the low byte of the current word
- out_single  out  1  word carries one byte only; the upper byte is 0
- out_last  out  1  current word is the final word of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final word transfers

## Operation
- States are IDLE, FETCH, SEND and DONE.
- Length: len = ((last_addr - first_addr) mod 16) + 1, range 1..16, held in a 5-bit remaining counter rem.
- Wrap-around: last_addr < first_addr wraps through 15 -> 0. first_addr == last_addr gives len = 1.
- Address advance: cur advances by 2 mod 16 per word. ra2 wraps to 0 when cur = 15.
- IDLE -> FETCH on start = 1. On that edge: cur <= first_addr, rem <= len, busy <= 1.
- FETCH -> SEND unconditionally. On that edge:
  - out_data <= {rd2, rd1}, out_addr <= cur, out_valid <= 1.
  - If rem == 1: out_single <= 1 and out_data[15:8] <= 0.
  - out_last <= (rem <= 2).
- SEND: out_data, out_addr, out_single and out_last are held stable while out_valid = 1 and out_ready = 0.
  - Transfer happens on the edge where out_valid && out_ready.
  - On transfer: out_valid <= 0 and rem <= rem - min(rem, 2).
  - If the new rem == 0, go to DONE; otherwise cur <= cur + 2 and go to FETCH.
- DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE.
- Start outside IDLE (FETCH, SEND or DONE) is ignored and not queued.
- Output words are snapshots taken at the FETCH edge. Register-file writes after that edge do not alter a pending word. The dump as a whole is not atomic.
- Reset (reset = 0 at a rising edge) overrides everything, including mid-dump:
  - state IDLE, cur = 0, rem = 0.
  - ra1 = 0, ra2 = 1.
  - out_valid, out_data, out_addr, out_single, out_last, busy and done all 0.
  - A partially sent dump is abandoned with no done pulse.

## Timing
- Start sampled at edge k:
  - busy = 1 and ra1 = first_addr from edge k.
  - First out_valid = 1 from edge k+1.
- Per word: one FETCH cycle plus at least one SEND cycle. Peak throughput with out_ready tied high is one word per 2 cycles.
- Total cycles from the start edge to the done pulse, with out_ready = 1: 2*ceil(len/2), then done during the following cycle.
- out_valid never drops without a transfer, except on reset.
- ra1/ra2 are registered-derived, so the register-file read path is a full cycle.

## Test plan
- Registers preloaded with reg[i] = 8'h10+i; start with first = 2, last = 5, out_ready = 1 -> words {16'h1312, addr 2}, then {16'h1514, addr 4, out_last}; done 1 cycle after the second transfer; busy low.
- first = 14, last = 1 (wrap, len 4) -> words 16'h1F1E @14, then 16'h1110 @0 with out_last.
- first = last = 7 -> one word 16'h0017 with out_single = 1 and out_last = 1.
- first = 0, last = 15; out_ready low for 3 cycles on every word -> 8 words with fields stable during each stall; a register write to reg[2] during the stall on word 0 does not change word 0.
- Start asserted again mid-dump (during SEND) -> ignored; word count unchanged.
- reset driven low during the second SEND of a 16-entry dump -> next edge gives all outputs 0 and IDLE; no done pulse; a fresh start then dumps correctly from first_addr.

Source files
------------

// File: rtl/reg_file_dump_if.sv
// Word stream from the register-file dump sequencer to its consumer.
// Each word carries two packed register bytes plus the address of the low byte.
interface reg_file_dump_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic [ADDR_W-1:0]     out_addr;
    logic                  out_single;
    logic                  out_last;

    modport master (
        output out_valid, out_data, out_addr, out_single, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_addr, out_single, out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_file_dump.sv
// Read-side sequencer for the register file: walks an inclusive, wrapping
// address range two entries at a time and streams packed words out.
module reg_file_dump #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   first_addr,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [ADDR_W-1:0]   ra1,
    output logic [ADDR_W-1:0]   ra2,
    input  logic [DATA_W-1:0]   rd1,
    input  logic [DATA_W-1:0]   rd2,
    output logic                busy,
    output logic                done,
    reg_file_dump_if.master     dump
);
    localparam int REM_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cur;
    logic [ADDR_W-1:0]   span;
    logic [REM_W-1:0]    rem, len, rem_step, rem_after;
    logic                xfer;

    // Range length wraps through the top of the file, so last < first is legal.
    assign span      = last_addr - first_addr;
    assign len       = {1'b0, span} + REM_W'(1);
    assign rem_step  = (rem >= REM_W'(2)) ? REM_W'(2) : rem;
    assign rem_after = rem - rem_step;
    assign xfer      = dump.out_valid && dump.out_ready;

    assign ra1  = cur;
    assign ra2  = cur + ADDR_W'(1);
    assign busy = (state == FETCH) || (state == SEND);
    assign done = (state == DONE);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = SEND;
            SEND:    if (xfer) state_nxt = (rem_after == '0) ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur             <= '0;
            rem             <= '0;
            dump.out_valid  <= 1'b0;
            dump.out_data   <= '0;
            dump.out_addr   <= '0;
            dump.out_single <= 1'b0;
            dump.out_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur <= first_addr;
                        rem <= len;
                    end
                end
                FETCH: begin
                    // Snapshot taken here; later register writes cannot disturb this word.
                    dump.out_data   <= (rem == REM_W'(1)) ? {{DATA_W{1'b0}}, rd1} : {rd2, rd1};
                    dump.out_addr   <= cur;
                    dump.out_single <= (rem == REM_W'(1));
                    dump.out_last   <= (rem <= REM_W'(2));
                    dump.out_valid  <= 1'b1;
                end
                SEND: begin
                    if (xfer) begin
                        dump.out_valid <= 1'b0;
                        rem            <= rem_after;
                        if (rem_after != '0) cur <= cur + ADDR_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: register-file model, scoreboard of
// expected words, stall stability, done-pulse and reset-abort checks.
module tb_reg_file_dump;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  addr;
        logic        single;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  first_addr, last_addr;
    logic [3:0]  ra1, ra2;
    logic [7:0]  rd1, rd2;
    logic        busy, done;
    logic [7:0]  regs [16];

    reg_file_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_file_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .busy       (busy),
        .done       (done),
        .dump       (bus)
    );

    always #5 clk = ~clk;

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    int    tests = 0;
    int    fails = 0;
    word_t exp_q[$];
    int    words_seen = 0;
    int    done_cnt = 0;
    logic  prev_done = 1'b0;
    logic  held_v = 1'b0;
    word_t held;
    word_t e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: stall stability, scoreboard pops on transfer, done pulse shape.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            held_v    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid_held", bus.out_valid, 1);
                check("stall_data", bus.out_data, held.data);
                check("stall_addr", bus.out_addr, held.addr);
                check("stall_single", bus.out_single, held.single);
                check("stall_last", bus.out_last, held.last);
            end
            held_v      = bus.out_valid && !bus.out_ready;
            held.data   = bus.out_data;
            held.addr   = bus.out_addr;
            held.single = bus.out_single;
            held.last   = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e.data);
                    check("word_addr", bus.out_addr, e.addr);
                    check("word_single", bus.out_single, e.single);
                    check("word_last", bus.out_last, e.last);
                end
                words_seen++;
            end
            if (done) begin
                check("done_busy_low", busy, 0);
                check("done_width", prev_done, 0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    // Runs one dump. stall: extra low-ready cycles per word; do_write: rewrite
    // reg[0]/reg[2] during the first stall; abort_word >= 0: pull reset then.
    task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int stall,
                            input bit do_write, input bit inj_start, input int abort_word);
        logic [7:0] m [16];
        word_t      w;
        int         len, nwords, cycles, cnt, words0, dones0;
        bit         injected;
        logic [3:0] a;
        int         r;

        m = regs;
        if (do_write) m[2] = 8'hA2;
        len    = int'(4'(l - f)) + 1;
        nwords = (len + 1) / 2;
        for (int i = 0; i < nwords; i++) begin
            a        = 4'(f + 4'(2 * i));
            r        = len - 2 * i;
            w.addr   = a;
            w.single = (r == 1);
            w.last   = (r <= 2);
            w.data   = (r == 1) ? {8'h00, m[a]} : {m[4'(a + 4'd1)], m[a]};
            exp_q.push_back(w);
        end

        words0 = words_seen;
        dones0 = done_cnt;
        first_addr    = f;
        last_addr     = l;
        bus.out_ready = (stall == 0);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ra1", ra1, f);
        check("start_ra2", ra2, 4'(f + 4'd1));
        check("start_valid_low", bus.out_valid, 0);

        cycles   = 0;
        cnt      = 0;
        injected = 0;
        while (!done && cycles < 200) begin
            if (abort_word >= 0 && bus.out_valid && (words_seen - words0) == abort_word) begin
                reset = 1'b0;
                break;
            end
            if (inj_start && bus.out_valid && !injected) begin
                start    = 1'b1;
                injected = 1;
            end else begin
                start = 1'b0;
            end
            if (stall > 0) begin
                if (!bus.out_valid) begin
                    bus.out_ready = 1'b0;
                    cnt = 0;
                end else if (!bus.out_ready) begin
                    cnt++;
                    if (do_write && cnt == 1 && words_seen == words0) begin
                        regs[0] = 8'hA0;
                        regs[2] = 8'hA2;
                    end
                    if (cnt > stall) bus.out_ready = 1'b1;
                end
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;

        if (abort_word < 0) begin
            check("cycles_to_done", cycles, nwords * (stall + 2));
            @(posedge clk); #1;
            check("busy_after_done", busy, 0);
            check("done_after_done", done, 0);
            check("valid_after_done", bus.out_valid, 0);
            check("word_count", words_seen - words0, nwords);
            check("done_pulses", done_cnt - dones0, 1);
            check("sb_drained", exp_q.size(), 0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_addr"}, bus.out_addr, 0);
        check({tag, "_single"}, bus.out_single, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ra1"}, ra1, 0);
        check({tag, "_ra2"}, ra2, 1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 16; i++) regs[i] = 8'(8'h10 + i);
        reset         = 1'b0;
        start         = 1'b0;
        first_addr    = '0;
        last_addr     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b1;
        @(posedge clk); #1;

        run_dump(4'd2, 4'd5, 0, 0, 0, -1);
        run_dump(4'd14, 4'd1, 0, 0, 0, -1);
        run_dump(4'd7, 4'd7, 0, 0, 0, -1);
        run_dump(4'd15, 4'd2, 0, 0, 0, -1);

        run_dump(4'd0, 4'd15, 3, 1, 0, -1);
        for (int i = 0; i < 16; i++) regs[i] = 8'(8'h10 + i);

        run_dump(4'd0, 4'd7, 0, 0, 1, -1);

        d0 = done_cnt;
        run_dump(4'd0, 4'd15, 0, 0, 0, 1);
        @(posedge clk); #1;
        check_reset_state("abort");
        exp_q.delete();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle_busy", busy, 0);

        run_dump(4'd9, 4'd12, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
